rs_pool: RTL and testbench

RS_POOL -- requirements
Module: rs_pool

---
 rtl/rs_pool.sv | 216 +++++++++++++++++++++
 tb/tb_rs_pool.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_pool.sv
// Reservation-station pool: operand capture and wakeup from the CDB, and
// oldest-first issue on each functional-unit port.
module rs_pool #(
   parameter int NUM_ENTRIES = 8,
   parameter int NUM_CDB     = 2,
   parameter int NUM_FU      = 4,
   parameter int TAG_W       = 5,
   parameter int XLEN        = 32,
   localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
   localparam int CNT_W = $clog2(NUM_ENTRIES + 1)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      dp_valid,
   output logic                      dp_ready,
   input  logic [FU_W-1:0]           dp_fu,
   input  logic [TAG_W-1:0]          dp_rob_tag,
   input  logic                      dp_src1_ready,
   input  logic                      dp_src2_ready,
   input  logic [TAG_W-1:0]          dp_src1_tag,
   input  logic [TAG_W-1:0]          dp_src2_tag,
   input  logic [XLEN-1:0]           dp_src1_value,
   input  logic [XLEN-1:0]           dp_src2_value,
   input  logic [31:0]               dp_inst,
   input  logic [NUM_CDB-1:0]        cdb_valid,
   input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
   input  logic [NUM_CDB*XLEN-1:0]   cdb_value,
   input  logic                      squash,
   input  logic [NUM_FU-1:0]         fu_ready,
   output logic [NUM_FU-1:0]         iss_valid,
   output logic [NUM_FU*TAG_W-1:0]   iss_rob_tag,
   output logic [NUM_FU*XLEN-1:0]    iss_v1,
   output logic [NUM_FU*XLEN-1:0]    iss_v2,
   output logic [NUM_FU*32-1:0]      iss_inst,
   output logic [CNT_W-1:0]          free_count
);
   localparam int IDX_W = $clog2(NUM_ENTRIES);

   typedef struct packed {
      logic            hit;
      logic [XLEN-1:0] value;
   } wake_t;

   // Scanning from the top channel down lets the lowest matching channel win.
   function automatic wake_t cdb_match(input logic [TAG_W-1:0] tag,
                                       input logic [NUM_CDB-1:0] vld,
                                       input logic [NUM_CDB*TAG_W-1:0] tags,
                                       input logic [NUM_CDB*XLEN-1:0] vals);
      wake_t res;
      res = '0;
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
         if (vld[k] && (tags[k*TAG_W +: TAG_W] == tag)) begin
            res.hit   = 1'b1;
            res.value = vals[k*XLEN +: XLEN];
         end
      end
      return res;
   endfunction

   logic [NUM_ENTRIES-1:0] busy_r;
   logic [NUM_ENTRIES-1:0] rdy1_r;
   logic [NUM_ENTRIES-1:0] rdy2_r;
   logic [FU_W-1:0]        fu_r   [NUM_ENTRIES];
   logic [TAG_W-1:0]       rob_r  [NUM_ENTRIES];
   logic [31:0]            inst_r [NUM_ENTRIES];
   logic [TAG_W-1:0]       tag1_r [NUM_ENTRIES];
   logic [TAG_W-1:0]       tag2_r [NUM_ENTRIES];
   logic [XLEN-1:0]        val1_r [NUM_ENTRIES];
   logic [XLEN-1:0]        val2_r [NUM_ENTRIES];
   // older_r[i][j] set means entry i was dispatched before entry j.
   logic [NUM_ENTRIES-1:0] older_r [NUM_ENTRIES];

   logic [CNT_W-1:0]       free_cnt_s;
   logic [IDX_W-1:0]       alloc_idx_s;
   logic                   accept_s;
   wake_t                  wake1_s [NUM_ENTRIES];
   wake_t                  wake2_s [NUM_ENTRIES];
   wake_t                  dp_wake1_s;
   wake_t                  dp_wake2_s;
   logic [NUM_ENTRIES-1:0] older_col_s [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] elig_s [NUM_FU];
   logic [NUM_ENTRIES-1:0] sel_s  [NUM_FU];
   logic [NUM_ENTRIES-1:0] issued_s;

   // Free-entry count and lowest-index free slot, from registered busy bits only.
   always_comb begin
      free_cnt_s  = '0;
      alloc_idx_s = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (!busy_r[i]) begin
            free_cnt_s  = free_cnt_s + CNT_W'(1);
            alloc_idx_s = IDX_W'(i);
         end else begin
            free_cnt_s  = free_cnt_s;
         end
      end
   end

   assign free_count = free_cnt_s;
   assign dp_ready   = (free_cnt_s != '0);
   assign accept_s   = dp_valid && dp_ready && !squash;

   // CDB tag matches for stored operands and for the incoming dispatch.
   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         wake1_s[i] = cdb_match(tag1_r[i], cdb_valid, cdb_tag, cdb_value);
         wake2_s[i] = cdb_match(tag2_r[i], cdb_valid, cdb_tag, cdb_value);
      end
      dp_wake1_s = cdb_match(dp_src1_tag, cdb_valid, cdb_tag, cdb_value);
      dp_wake2_s = cdb_match(dp_src2_tag, cdb_valid, cdb_tag, cdb_value);
   end

   // Transpose of the age matrix: older_col_s[i][j] means j is older than i.
   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         for (int j = 0; j < NUM_ENTRIES; j++) begin
            older_col_s[i][j] = older_r[j][i];
         end
      end
   end

   // Per-port eligibility.
   always_comb begin
      for (int f = 0; f < NUM_FU; f++) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            elig_s[f][i] = busy_r[i] & rdy1_r[i] & rdy2_r[i] &
                           (fu_r[i] == FU_W'(f)) & fu_ready[f];
         end
      end
   end

   // Oldest eligible entry per port: one with no older eligible competitor.
   always_comb begin
      issued_s = '0;
      for (int f = 0; f < NUM_FU; f++) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            sel_s[f][i] = elig_s[f][i] & ~(|(elig_s[f] & older_col_s[i]));
         end
         issued_s = issued_s | sel_s[f];
      end
   end

   // Issue-port AND-OR mux of the selected entry's fields.
   always_comb begin
      iss_valid   = '0;
      iss_rob_tag = '0;
      iss_v1      = '0;
      iss_v2      = '0;
      iss_inst    = '0;
      for (int f = 0; f < NUM_FU; f++) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            iss_valid[f] = iss_valid[f] | (sel_s[f][i] & ~squash);
            iss_rob_tag[f*TAG_W +: TAG_W] = iss_rob_tag[f*TAG_W +: TAG_W] |
                                            ({TAG_W{sel_s[f][i]}} & rob_r[i]);
            iss_v1[f*XLEN +: XLEN] = iss_v1[f*XLEN +: XLEN] | ({XLEN{sel_s[f][i]}} & val1_r[i]);
            iss_v2[f*XLEN +: XLEN] = iss_v2[f*XLEN +: XLEN] | ({XLEN{sel_s[f][i]}} & val2_r[i]);
            iss_inst[f*32 +: 32]   = iss_inst[f*32 +: 32] | ({32{sel_s[f][i]}} & inst_r[i]);
         end
      end
   end

   // Entry state: allocation, wakeup, issue release, squash and reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy_r <= '0;
         rdy1_r <= '0;
         rdy2_r <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            fu_r[i]    <= '0;
            rob_r[i]   <= '0;
            inst_r[i]  <= '0;
            tag1_r[i]  <= '0;
            tag2_r[i]  <= '0;
            val1_r[i]  <= '0;
            val2_r[i]  <= '0;
            older_r[i] <= '0;
         end
      end else if (squash) begin
         busy_r <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            older_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (issued_s[i]) begin
               busy_r[i] <= 1'b0;
            end
            if (busy_r[i] && !rdy1_r[i] && wake1_s[i].hit) begin
               rdy1_r[i] <= 1'b1;
               val1_r[i] <= wake1_s[i].value;
            end
            if (busy_r[i] && !rdy2_r[i] && wake2_s[i].hit) begin
               rdy2_r[i] <= 1'b1;
               val2_r[i] <= wake2_s[i].value;
            end
         end
         if (accept_s) begin
            busy_r[alloc_idx_s] <= 1'b1;
            fu_r[alloc_idx_s]   <= dp_fu;
            rob_r[alloc_idx_s]  <= dp_rob_tag;
            inst_r[alloc_idx_s] <= dp_inst;
            tag1_r[alloc_idx_s] <= dp_src1_tag;
            tag2_r[alloc_idx_s] <= dp_src2_tag;
            rdy1_r[alloc_idx_s] <= dp_src1_ready | dp_wake1_s.hit;
            rdy2_r[alloc_idx_s] <= dp_src2_ready | dp_wake2_s.hit;
            val1_r[alloc_idx_s] <= dp_src1_ready ? dp_src1_value : dp_wake1_s.value;
            val2_r[alloc_idx_s] <= dp_src2_ready ? dp_src2_value : dp_wake2_s.value;
            // New entry becomes the youngest relative to every other slot.
            for (int j = 0; j < NUM_ENTRIES; j++) begin
               older_r[alloc_idx_s][j] <= 1'b0;
               older_r[j][alloc_idx_s] <= (IDX_W'(j) != alloc_idx_s);
            end
         end
      end
   end
endmodule

// File: tb/tb_rs_pool.sv
// Self-checking bench for rs_pool: directed scenarios plus randomized traffic
// checked against a sequence-number reference model.
module tb_rs_pool;
   localparam int N  = 8;
   localparam int NC = 2;
   localparam int NF = 4;
   localparam int TW = 5;
   localparam int XL = 32;
   localparam int FW = 2;
   localparam int CW = 4;

   logic           clock = 1'b0;
   logic           reset;
   logic           dp_valid;
   logic           dp_ready;
   logic [FW-1:0]  dp_fu;
   logic [TW-1:0]  dp_rob_tag;
   logic           dp_src1_ready, dp_src2_ready;
   logic [TW-1:0]  dp_src1_tag, dp_src2_tag;
   logic [XL-1:0]  dp_src1_value, dp_src2_value;
   logic [31:0]    dp_inst;
   logic [NC-1:0]  cdb_valid;
   logic [NC*TW-1:0] cdb_tag;
   logic [NC*XL-1:0] cdb_value;
   logic           squash;
   logic [NF-1:0]  fu_ready;
   logic [NF-1:0]  iss_valid;
   logic [NF*TW-1:0] iss_rob_tag;
   logic [NF*XL-1:0] iss_v1, iss_v2;
   logic [NF*32-1:0] iss_inst;
   logic [CW-1:0]  free_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   rs_pool #(.NUM_ENTRIES(N), .NUM_CDB(NC), .NUM_FU(NF), .TAG_W(TW), .XLEN(XL)) dut (
      .clock(clock), .reset(reset),
      .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_fu(dp_fu), .dp_rob_tag(dp_rob_tag),
      .dp_src1_ready(dp_src1_ready), .dp_src2_ready(dp_src2_ready),
      .dp_src1_tag(dp_src1_tag), .dp_src2_tag(dp_src2_tag),
      .dp_src1_value(dp_src1_value), .dp_src2_value(dp_src2_value), .dp_inst(dp_inst),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .squash(squash), .fu_ready(fu_ready),
      .iss_valid(iss_valid), .iss_rob_tag(iss_rob_tag), .iss_v1(iss_v1), .iss_v2(iss_v2),
      .iss_inst(iss_inst), .free_count(free_count)
   );

   // Reference model: a set of slots, age expressed as a dispatch sequence number.
   bit            m_busy [N];
   int            m_fu   [N];
   logic [TW-1:0] m_rob  [N];
   logic [31:0]   m_inst [N];
   bit            m_r1 [N], m_r2 [N];
   logic [TW-1:0] m_t1 [N], m_t2 [N];
   logic [XL-1:0] m_v1 [N], m_v2 [N];
   longint        m_seq [N];
   longint        seq_ctr;

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      seq_ctr = 0;
   endtask

   function automatic int model_free();
      int c = 0;
      for (int i = 0; i < N; i++) if (!m_busy[i]) c++;
      return c;
   endfunction

   function automatic int model_pick(int f);
      int best = -1;
      for (int i = 0; i < N; i++)
         if (m_busy[i] && m_r1[i] && m_r2[i] && m_fu[i] == f && fu_ready[f] && !squash)
            if (best < 0 || m_seq[i] < m_seq[best]) best = i;
      return best;
   endfunction

   function automatic bit cdb_hit(input logic [TW-1:0] t, output logic [XL-1:0] v);
      for (int k = 0; k < NC; k++)
         if (cdb_valid[k] && cdb_tag[k*TW +: TW] == t) begin
            v = cdb_value[k*XL +: XL];
            return 1'b1;
         end
      v = '0;
      return 1'b0;
   endfunction

   task automatic model_step();
      int pick [NF];
      int fi;
      logic [XL-1:0] v;
      bit acc;
      acc = dp_valid && model_free() != 0 && !squash;
      fi = -1;
      for (int i = 0; i < N; i++) if (!m_busy[i] && fi < 0) fi = i;
      for (int f = 0; f < NF; f++) pick[f] = model_pick(f);
      if (squash) begin
         for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (m_busy[i] && !m_r1[i] && cdb_hit(m_t1[i], v)) begin m_r1[i] = 1'b1; m_v1[i] = v; end
            if (m_busy[i] && !m_r2[i] && cdb_hit(m_t2[i], v)) begin m_r2[i] = 1'b1; m_v2[i] = v; end
         end
         for (int f = 0; f < NF; f++) if (pick[f] >= 0) m_busy[pick[f]] = 1'b0;
         if (acc) begin
            m_busy[fi] = 1'b1; m_fu[fi] = int'(dp_fu); m_rob[fi] = dp_rob_tag;
            m_inst[fi] = dp_inst; m_seq[fi] = seq_ctr; seq_ctr++;
            m_t1[fi] = dp_src1_tag; m_t2[fi] = dp_src2_tag;
            if (dp_src1_ready) begin m_r1[fi] = 1'b1; m_v1[fi] = dp_src1_value; end
            else begin m_r1[fi] = cdb_hit(dp_src1_tag, v); m_v1[fi] = v; end
            if (dp_src2_ready) begin m_r2[fi] = 1'b1; m_v2[fi] = dp_src2_value; end
            else begin m_r2[fi] = cdb_hit(dp_src2_tag, v); m_v2[fi] = v; end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_idle();
      dp_valid = 1'b0; cdb_valid = '0; squash = 1'b0;
   endtask

   task automatic set_dp(input int fu, input int rob, input bit r1, input int t1, input logic [31:0] v1,
                         input bit r2, input int t2, input logic [31:0] v2);
      dp_valid = 1'b1; dp_fu = FW'(fu); dp_rob_tag = TW'(rob);
      dp_src1_ready = r1; dp_src1_tag = TW'(t1); dp_src1_value = v1;
      dp_src2_ready = r2; dp_src2_tag = TW'(t2); dp_src2_value = v2;
      dp_inst = 32'h1000_0000 | 32'(rob);
   endtask

   task automatic test_reset();
      reset = 1'b1; fu_ready = '1;
      drive_idle();
      set_dp(0, 0, 1'b1, 0, 32'h0, 1'b1, 0, 32'h0);
      dp_valid = 1'b0;
      cdb_tag = '0; cdb_value = '0;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      n_cmp++; if (free_count !== 4'(N)) begin n_err++; $display("FAIL reset_free: got %0d expected %0d", free_count, N); end
      n_cmp++; if (dp_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", dp_ready); end
      n_cmp++; if (iss_valid !== 4'b0000) begin n_err++; $display("FAIL reset_iss: got %b expected 0000", iss_valid); end
      reset = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_basic();
      fu_ready = '1;
      set_dp(0, 3, 1'b1, 0, 32'h10, 1'b1, 0, 32'h20);
      #1;
      n_cmp++; if (free_count !== 4'd8) begin n_err++; $display("FAIL basic_free0: got %0d expected 8", free_count); end
      tick();
      drive_idle(); #1;
      n_cmp++; if (iss_valid !== 4'b0001) begin n_err++; $display("FAIL basic_valid: got %b expected 0001", iss_valid); end
      n_cmp++; if (iss_v1[31:0] !== 32'h10 || iss_v2[31:0] !== 32'h20) begin n_err++;
         $display("FAIL basic_vals: got %h/%h expected 10/20", iss_v1[31:0], iss_v2[31:0]); end
      n_cmp++; if (iss_rob_tag[4:0] !== 5'd3 || iss_inst[31:0] !== 32'h1000_0003) begin n_err++;
         $display("FAIL basic_rob: got %0d/%h expected 3/10000003", iss_rob_tag[4:0], iss_inst[31:0]); end
      n_cmp++; if (free_count !== 4'd7) begin n_err++; $display("FAIL basic_free1: got %0d expected 7", free_count); end
      tick();
      n_cmp++; if (free_count !== 4'd8 || iss_valid !== 4'b0000) begin n_err++;
         $display("FAIL basic_free2: got %0d/%b expected 8/0000", free_count, iss_valid); end
   endtask

   task automatic test_wakeup();
      fu_ready = '1;
      set_dp(0, 4, 1'b0, 7, 32'h0, 1'b1, 0, 32'h1);
      tick();
      drive_idle(); #1;
      n_cmp++; if (iss_valid !== 4'b0000) begin n_err++; $display("FAIL wake_wait: got %b expected 0000", iss_valid); end
      tick();
      cdb_valid = 2'b10; cdb_tag[9:5] = 5'd7; cdb_value[63:32] = 32'hABCD; #1;
      n_cmp++; if (iss_valid !== 4'b0000) begin n_err++; $display("FAIL wake_nobypass: got %b expected 0000", iss_valid); end
      tick();
      drive_idle(); #1;
      n_cmp++; if (iss_valid !== 4'b0001 || iss_v1[31:0] !== 32'hABCD || iss_rob_tag[4:0] !== 5'd4) begin n_err++;
         $display("FAIL wake_issue: got %b/%h/%0d expected 0001/abcd/4", iss_valid, iss_v1[31:0], iss_rob_tag[4:0]); end
      tick();
   endtask

   task automatic test_capture_and_dup();
      fu_ready = '1;
      set_dp(0, 5, 1'b1, 0, 32'h1, 1'b0, 9, 32'h0);
      cdb_valid = 2'b01; cdb_tag[4:0] = 5'd9; cdb_value[31:0] = 32'h55;
      tick();
      drive_idle(); #1;
      n_cmp++; if (iss_valid !== 4'b0001 || iss_v2[31:0] !== 32'h55) begin n_err++;
         $display("FAIL capture: got %b/%h expected 0001/55", iss_valid, iss_v2[31:0]); end
      tick();
      set_dp(1, 6, 1'b0, 11, 32'h0, 1'b1, 0, 32'h2);
      tick();
      drive_idle();
      cdb_valid = 2'b11; cdb_tag = {5'd11, 5'd11}; cdb_value = {32'h222, 32'h111};
      tick();
      drive_idle(); #1;
      n_cmp++; if (iss_valid !== 4'b0010 || iss_v1[63:32] !== 32'h111) begin n_err++;
         $display("FAIL dup_tag: got %b/%h expected 0010/111", iss_valid, iss_v1[63:32]); end
      tick();
   endtask

   task automatic test_full();
      fu_ready = 4'b1101;
      for (int i = 0; i < N; i++) begin
         set_dp(1, 10 + i, 1'b1, 0, 32'(i), 1'b1, 0, 32'(i));
         tick();
      end
      set_dp(1, 31, 1'b1, 0, 32'h9, 1'b1, 0, 32'h9); #1;
      n_cmp++; if (dp_ready !== 1'b0 || free_count !== 4'd0) begin n_err++;
         $display("FAIL full_ready: got %b/%0d expected 0/0", dp_ready, free_count); end
      tick();
      drive_idle(); #1;
      n_cmp++; if (free_count !== 4'd0) begin n_err++; $display("FAIL full_ignored: got %0d expected 0", free_count); end
      fu_ready = '1;
      for (int i = 0; i < N; i++) begin
         #1;
         n_cmp++; if (iss_valid !== 4'b0010 || iss_rob_tag[9:5] !== 5'(10 + i)) begin n_err++;
            $display("FAIL full_order%0d: got %b/%0d expected 0010/%0d", i, iss_valid, iss_rob_tag[9:5], 10 + i); end
         tick();
      end
      n_cmp++; if (free_count !== 4'd8 || iss_valid !== 4'b0000) begin n_err++;
         $display("FAIL full_drain: got %0d/%b expected 8/0000", free_count, iss_valid); end
   endtask

   task automatic test_multi_and_squash();
      fu_ready = '0;
      set_dp(2, 1, 1'b1, 0, 32'hA, 1'b1, 0, 32'hA); tick();
      set_dp(2, 2, 1'b1, 0, 32'hB, 1'b1, 0, 32'hB); tick();
      set_dp(0, 6, 1'b1, 0, 32'hC, 1'b1, 0, 32'hC); tick();
      drive_idle(); fu_ready = '1; #1;
      n_cmp++; if (iss_valid !== 4'b0101 || iss_rob_tag[14:10] !== 5'd1 || iss_rob_tag[4:0] !== 5'd6) begin n_err++;
         $display("FAIL multi_port: got %b/%0d/%0d expected 0101/1/6", iss_valid, iss_rob_tag[14:10], iss_rob_tag[4:0]); end
      tick();
      n_cmp++; if (iss_valid !== 4'b0100 || iss_rob_tag[14:10] !== 5'd2) begin n_err++;
         $display("FAIL multi_second: got %b/%0d expected 0100/2", iss_valid, iss_rob_tag[14:10]); end
      tick();
      fu_ready = '0;
      set_dp(3, 20, 1'b1, 0, 32'h1, 1'b1, 0, 32'h1); tick();
      set_dp(3, 21, 1'b1, 0, 32'h2, 1'b1, 0, 32'h2); tick();
      set_dp(0, 22, 1'b1, 0, 32'h3, 1'b1, 0, 32'h3);
      squash = 1'b1; fu_ready = '1; #1;
      n_cmp++; if (iss_valid !== 4'b0000 || free_count !== 4'd6) begin n_err++;
         $display("FAIL squash_same: got %b/%0d expected 0000/6", iss_valid, free_count); end
      tick();
      drive_idle(); #1;
      n_cmp++; if (free_count !== 4'd8 || iss_valid !== 4'b0000) begin n_err++;
         $display("FAIL squash_next: got %0d/%b expected 8/0000", free_count, iss_valid); end
      tick();
   endtask

   task automatic test_async_reset();
      fu_ready = '0;
      set_dp(3, 12, 1'b1, 0, 32'h1, 1'b1, 0, 32'h1); tick();
      set_dp(3, 13, 1'b1, 0, 32'h2, 1'b1, 0, 32'h2); tick();
      drive_idle(); fu_ready = '1; #1;
      n_cmp++; if (free_count !== 4'd6 || iss_valid !== 4'b1000) begin n_err++;
         $display("FAIL areset_pre: got %0d/%b expected 6/1000", free_count, iss_valid); end
      #1 reset = 1'b1;
      #1;
      n_cmp++; if (free_count !== 4'd8 || iss_valid !== 4'b0000) begin n_err++;
         $display("FAIL areset_now: got %0d/%b expected 8/0000", free_count, iss_valid); end
      #1 reset = 1'b0;
      model_reset();
      @(posedge clock); #1;
   endtask

   task automatic test_random();
      int p;
      logic [NF-1:0] ev;
      for (int c = 0; c < 600; c++) begin
         dp_valid = ($urandom_range(0, 9) < 6);
         dp_fu = FW'($urandom_range(0, NF - 1));
         dp_rob_tag = TW'($urandom);
         dp_src1_ready = $urandom_range(0, 1); dp_src2_ready = $urandom_range(0, 1);
         dp_src1_tag = TW'($urandom_range(0, 7)); dp_src2_tag = TW'($urandom_range(0, 7));
         dp_src1_value = $urandom; dp_src2_value = $urandom; dp_inst = $urandom;
         cdb_valid = NC'($urandom);
         for (int k = 0; k < NC; k++) begin
            cdb_tag[k*TW +: TW] = TW'($urandom_range(0, 7));
            cdb_value[k*XL +: XL] = $urandom;
         end
         squash = ($urandom_range(0, 39) == 0);
         fu_ready = NF'($urandom);
         #1;
         ev = '0;
         for (int f = 0; f < NF; f++) begin
            p = model_pick(f);
            ev[f] = (p >= 0);
            if (p >= 0) begin
               n_cmp++;
               if (iss_rob_tag[f*TW +: TW] !== m_rob[p] || iss_v1[f*XL +: XL] !== m_v1[p] ||
                   iss_v2[f*XL +: XL] !== m_v2[p] || iss_inst[f*32 +: 32] !== m_inst[p]) begin
                  n_err++;
                  $display("FAIL rand_fields c%0d p%0d: got %0d/%h/%h/%h expected %0d/%h/%h/%h", c, f,
                           iss_rob_tag[f*TW +: TW], iss_v1[f*XL +: XL], iss_v2[f*XL +: XL], iss_inst[f*32 +: 32],
                           m_rob[p], m_v1[p], m_v2[p], m_inst[p]);
               end
            end
         end
         n_cmp++; if (iss_valid !== ev) begin n_err++; $display("FAIL rand_valid c%0d: got %b expected %b", c, iss_valid, ev); end
         n_cmp++; if (free_count !== CW'(model_free()) || dp_ready !== (model_free() != 0)) begin n_err++;
            $display("FAIL rand_free c%0d: got %0d/%b expected %0d", c, free_count, dp_ready, model_free()); end
         tick();
      end
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wakeup();
      test_capture_and_dup();
      test_full();
      test_multi_and_squash();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
